wb_pipe_reg: RTL and testbench
==============================

// Module: wb_pipe_reg
// PURPOSE
//  Parametrised MEM->WB pipeline boundary register carrying N_CH independent write channels.
//  Each channel carries wen/addr/data; channels cover GPR, HI/LO and LLbit style writes.
//  Decodes the global stall vector at stage index STAGE, supports an exception flush and a valid bit.
//  Sits between the memory stage and the writeback/regfile; its outputs also feed forwarding muxes.
// PARAMETERS
//  N_CH     3   number of write channels (>=1)
//  DATA_W   32  data width per channel
//  ADDR_W   5   address width per channel; channels without an address ignore it
//  STALL_W  6   width of the global stall vector
//  STAGE    4   stall bit owned by the upstream stage; downstream bit is STAGE+1 (STAGE<=STALL_W-2)
//  CNT_W    16  width of the performance counters
// PORTS
//  i_clk         in   1               clock, rising edge
//  i_rst         in   1               synchronous reset, active-high
//  i_stall       in   STALL_W         stall vector, 1=STOP per stage
//  i_flush       in   1               exception/flush; kills the in-flight entry
//  i_valid       in   1               upstream entry is a real instruction
//  i_wen         in   N_CH            per-channel write enable
//  i_waddr       in   N_CH*ADDR_W     per-channel address, channel k at [k*ADDR_W +: ADDR_W]
//  i_wdata       in   N_CH*DATA_W     per-channel data, channel k at [k*DATA_W +: DATA_W]
//  o_valid       out  1               registered entry valid
//  o_wen         out  N_CH            registered write enables
//  o_waddr       out  N_CH*ADDR_W     registered addresses
//  o_wdata       out  N_CH*DATA_W     registered data
//  o_bubble_cnt  out  CNT_W           bubbles inserted (perf; macro-gated)
//  o_hold_cnt    out  CNT_W           cycles held (perf; macro-gated)
// BEHAVIOUR
//  - Single clock i_clk; i_rst is synchronous and active-high. All state updates on the rising edge.
//  - Reset: o_valid=0, o_wen=0, o_waddr=0, o_wdata=0, both counters=0.
//  - Action priority per edge (exactly one applies):
//    1. RESET when i_rst.
//    2. FLUSH when i_flush, regardless of the stall bits: o_valid=0, all o_wen=0, addr/data=0.
//    3. BUBBLE when stall[STAGE]=1 and stall[STAGE+1]=0: same outputs as FLUSH; bubble_cnt+1.
//    4. ADVANCE when stall[STAGE]=0: capture i_valid/i_wen/i_waddr/i_wdata.
//       An entry with i_valid=0 captures o_wen=0 on every channel (wen masked by valid).
//    5. HOLD otherwise (both stages stalled): all outputs keep their value; hold_cnt+1.
//  - Latency is 1 cycle input->output on ADVANCE. No combinational path from inputs to outputs.
//  - Channels are independent: any subset of o_wen may be high in the same cycle.
//  - Counters saturate at all-ones and never wrap. FLUSH does not clear them; only i_rst does.
//  - Flush while in HOLD discards the held entry on that edge.
//  - A stall bit that is X/unknown is an illegal input; the bench asserts against it.
// CONFIGURATION
//  WB_PIPE_PERF_EN defined: bubble/hold counters are implemented as specified above.
//  WB_PIPE_PERF_EN undefined: no counter flops; o_bubble_cnt and o_hold_cnt are tied to 0.
//  All other behaviour is identical with and without the macro.
// STRUCTURE
//  pipe_pkg (shared): STOP/NO_STOP constants, the typedef enum stage_act_e
//    {ACT_RESET, ACT_FLUSH, ACT_BUBBLE, ACT_ADVANCE, ACT_HOLD}, and function sat_inc().
//  Sub-module pipe_stall_decode: combinational (rst, flush, stall[STAGE], stall[STAGE+1]) -> stage_act_e.
//    It is reused by every pipeline boundary register.
//  wb_pipe_reg instantiates the decoder and contains one always_ff, a case on the action.
//  Compile-time assertions: N_CH>=1 and STAGE<=STALL_W-2.
// TESTING
//  T1 reset: i_rst=1 for 2 cycles, inputs at random -> all outputs 0 on the following cycle; counters 0.
//  T2 advance: stall=6'b0, valid=1, wen=3'b101, ch0 addr=5'd7 data=32'hDEAD_BEEF
//     -> next cycle o_wen=3'b101, ch0 addr 7, data DEAD_BEEF.
//  T3 bubble: stall=6'b01_0000 for 3 cycles -> o_valid=0, o_wen=0 each cycle; bubble_cnt=3.
//  T4 hold: load entry X, then stall=6'b11_0000 for 5 cycles -> X stable for 5 cycles; hold_cnt=5.
//     Release stall -> new input captured.
//  T5 flush priority: stall=6'b11_0000 and i_flush=1 -> entry cleared next cycle; hold_cnt unchanged.
//  T6 saturation/config: CNT_W=4, 20 bubble cycles -> bubble_cnt=4'hF.
//     Rebuild without WB_PIPE_PERF_EN -> both counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline boundary registers: stall encoding, per-edge action
// type and a saturating counter increment.
package pipe_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Widest counter sat_inc() can handle.
  localparam int unsigned SAT_MAX_W = 32;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADVANCE,
    ACT_HOLD
  } stage_act_e;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(logic [SAT_MAX_W-1:0] val,
                                                   int unsigned width);
    logic [SAT_MAX_W:0] lim;
    lim = (33'd1 << width) - 33'd1;
    if ({1'b0, val} >= lim) begin
      return val;
    end
    return val + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_stall_decode.sv
// Decodes reset, flush and the two stall bits around a pipeline boundary into the single
// action that boundary register takes on the next rising edge.
module pipe_stall_decode
  import pipe_pkg::*;
(
  input  logic       i_rst,
  input  logic       i_flush,
  input  logic       i_stall_up,
  input  logic       i_stall_dn,
  output stage_act_e o_act
);

  always_comb begin
    o_act = ACT_HOLD;
    if (i_rst) begin
      o_act = ACT_RESET;
    end else if (i_flush) begin
      o_act = ACT_FLUSH;
    end else if (i_stall_up == STOP && i_stall_dn == NO_STOP) begin
      // Upstream stopped but downstream drains: insert an empty slot.
      o_act = ACT_BUBBLE;
    end else if (i_stall_up == NO_STOP) begin
      o_act = ACT_ADVANCE;
    end else begin
      o_act = ACT_HOLD;
    end
  end

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM->WB boundary register with N_CH independent write channels, stall/flush handling and
// optional bubble/hold perf counters (enabled by defining WB_PIPE_PERF_EN).
module wb_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned N_CH    = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned STAGE   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [STALL_W-1:0]       i_stall,
  input  logic                     i_flush,
  input  logic                     i_valid,
  input  logic [N_CH-1:0]          i_wen,
  input  logic [N_CH*ADDR_W-1:0]   i_waddr,
  input  logic [N_CH*DATA_W-1:0]   i_wdata,
  output logic                     o_valid,
  output logic [N_CH-1:0]          o_wen,
  output logic [N_CH*ADDR_W-1:0]   o_waddr,
  output logic [N_CH*DATA_W-1:0]   o_wdata,
  output logic [CNT_W-1:0]         o_bubble_cnt,
  output logic [CNT_W-1:0]         o_hold_cnt
);

  if (N_CH < 1) begin : g_bad_n_ch
    $error("wb_pipe_reg: N_CH must be at least 1");
  end
  if (STAGE + 2 > STALL_W) begin : g_bad_stage
    $error("wb_pipe_reg: STAGE must be at most STALL_W-2");
  end
  if (CNT_W < 1 || CNT_W > SAT_MAX_W) begin : g_bad_cnt_w
    $error("wb_pipe_reg: CNT_W must be within 1..32");
  end

  stage_act_e act;

  pipe_stall_decode u_decode (
    .i_rst      (i_rst),
    .i_flush    (i_flush),
    .i_stall_up (i_stall[STAGE]),
    .i_stall_dn (i_stall[STAGE+1]),
    .o_act      (act)
  );

  // Only two stall bits matter at this boundary.
  logic unused_stall;
  assign unused_stall = ^i_stall;

`ifdef WB_PIPE_PERF_EN
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] hold_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;
  assign o_hold_cnt   = hold_cnt_q;
`else
  assign o_bubble_cnt = '0;
  assign o_hold_cnt   = '0;
`endif

  always_ff @(posedge i_clk) begin
    case (act)
      ACT_RESET: begin
        o_valid <= 1'b0;
        o_wen   <= '0;
        o_waddr <= '0;
        o_wdata <= '0;
`ifdef WB_PIPE_PERF_EN
        bubble_cnt_q <= '0;
        hold_cnt_q   <= '0;
`endif
      end
      ACT_FLUSH: begin
        o_valid <= 1'b0;
        o_wen   <= '0;
        o_waddr <= '0;
        o_wdata <= '0;
      end
      ACT_BUBBLE: begin
        o_valid <= 1'b0;
        o_wen   <= '0;
        o_waddr <= '0;
        o_wdata <= '0;
`ifdef WB_PIPE_PERF_EN
        bubble_cnt_q <= CNT_W'(sat_inc(SAT_MAX_W'(bubble_cnt_q), CNT_W));
`endif
      end
      ACT_ADVANCE: begin
        o_valid <= i_valid;
        // A non-instruction slot must never write any register file.
        o_wen   <= i_valid ? i_wen : '0;
        o_waddr <= i_waddr;
        o_wdata <= i_wdata;
      end
      ACT_HOLD: begin
`ifdef WB_PIPE_PERF_EN
        hold_cnt_q <= CNT_W'(sat_inc(SAT_MAX_W'(hold_cnt_q), CNT_W));
`endif
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg: reset, advance, bubble, hold, flush priority and counter
// saturation (a second instance with 4-bit counters).
module tb_wb_pipe_reg;

`ifdef WB_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic         flush;
  logic         valid;
  logic [2:0]   wen;
  logic [14:0]  waddr;
  logic [95:0]  wdata;

  logic         o_valid, o_valid4;
  logic [2:0]   o_wen, o_wen4;
  logic [14:0]  o_waddr, o_waddr4;
  logic [95:0]  o_wdata, o_wdata4;
  logic [15:0]  bubble_cnt, hold_cnt;
  logic [3:0]   bubble_cnt4, hold_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_pipe_reg u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_valid      (valid),
    .i_wen        (wen),
    .i_waddr      (waddr),
    .i_wdata      (wdata),
    .o_valid      (o_valid),
    .o_wen        (o_wen),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_bubble_cnt (bubble_cnt),
    .o_hold_cnt   (hold_cnt)
  );

  wb_pipe_reg #(.CNT_W(4)) u_dut4 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_valid      (valid),
    .i_wen        (wen),
    .i_waddr      (waddr),
    .i_wdata      (wdata),
    .o_valid      (o_valid4),
    .o_wen        (o_wen4),
    .o_waddr      (o_waddr4),
    .o_wdata      (o_wdata4),
    .o_bubble_cnt (bubble_cnt4),
    .o_hold_cnt   (hold_cnt4)
  );

  // Unknown stall bits are illegal stimulus.
  always @(posedge clk) begin
    assert (!$isunknown(stall)) else begin
      errors++;
      $error("FAIL stall_known: got %b required no X/Z", stall);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_entry(input string tag, input logic v, input logic [2:0] w,
                             input logic [14:0] a, input logic [95:0] d);
    check({tag, "_valid"}, 128'(o_valid), 128'(v));
    check({tag, "_wen"},   128'(o_wen),   128'(w));
    check({tag, "_waddr"}, 128'(o_waddr), 128'(a));
    check({tag, "_wdata"}, 128'(o_wdata), 128'(d));
  endtask

  task automatic check_cnt(input string tag, input int b, input int h, input int b4, input int h4);
    check({tag, "_bubble"},  128'(bubble_cnt),  PERF ? 128'(b)  : 128'(0));
    check({tag, "_hold"},    128'(hold_cnt),    PERF ? 128'(h)  : 128'(0));
    check({tag, "_bubble4"}, 128'(bubble_cnt4), PERF ? 128'(b4) : 128'(0));
    check({tag, "_hold4"},   128'(hold_cnt4),   PERF ? 128'(h4) : 128'(0));
  endtask

  logic [14:0] addr_x, addr_y;
  logic [95:0] data_x, data_y;

  initial begin
    // T1 reset with random inputs
    rst   = 1'b1;
    stall = 6'($urandom);
    flush = 1'($urandom);
    valid = 1'($urandom);
    wen   = 3'($urandom);
    waddr = 15'($urandom);
    wdata = {$urandom, $urandom, $urandom};
    tick();
    tick();
    check_entry("reset", 1'b0, 3'b000, 15'd0, 96'd0);
    check_cnt("reset", 0, 0, 0, 0);

    // T2 advance
    rst   = 1'b0;
    flush = 1'b0;
    stall = 6'b00_0000;
    valid = 1'b1;
    wen   = 3'b101;
    waddr = {5'd3, 5'd9, 5'd7};
    wdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};
    tick();
    check_entry("advance", 1'b1, 3'b101, {5'd3, 5'd9, 5'd7},
                {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF});
    check("advance_ch0_addr", 128'(o_waddr[4:0]), 128'(5'd7));
    check("advance_ch0_data", 128'(o_wdata[31:0]), 128'(32'hDEAD_BEEF));

    // Inputs change between edges: outputs must not follow.
    wen   = 3'b010;
    wdata = 96'h1;
    #3;
    check("no_comb_path_wen", 128'(o_wen), 128'(3'b101));

    // Invalid entry masks all write enables
    valid = 1'b0;
    wen   = 3'b111;
    waddr = {5'd1, 5'd2, 5'd3};
    wdata = {32'hA, 32'hB, 32'hC};
    tick();
    check_entry("invalid", 1'b0, 3'b000, {5'd1, 5'd2, 5'd3}, {32'hA, 32'hB, 32'hC});

    // T3 bubble for 3 cycles
    valid = 1'b1;
    stall = 6'b01_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_entry("bubble", 1'b0, 3'b000, 15'd0, 96'd0);
    end
    check_cnt("bubble", 3, 0, 3, 0);

    // T4 load X, hold 5 cycles, release to Y
    addr_x = {5'd31, 5'd17, 5'd4};
    data_x = {32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    addr_y = {5'd8, 5'd16, 5'd24};
    data_y = {32'h0BAD_F00D, 32'h1234_5678, 32'h8765_4321};
    stall = 6'b00_0000;
    valid = 1'b1;
    wen   = 3'b011;
    waddr = addr_x;
    wdata = data_x;
    tick();
    check_entry("load_x", 1'b1, 3'b011, addr_x, data_x);
    stall = 6'b11_0000;
    wen   = 3'b110;
    waddr = addr_y;
    wdata = data_y;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_entry("hold", 1'b1, 3'b011, addr_x, data_x);
    end
    check_cnt("hold", 3, 5, 3, 5);
    stall = 6'b00_0000;
    tick();
    check_entry("release", 1'b1, 3'b110, addr_y, data_y);

    // Lower stall bits are not owned by this boundary
    stall = 6'b00_1111;
    wen   = 3'b111;
    tick();
    check("other_bits_wen", 128'(o_wen), 128'(3'b111));

    // T5 flush while both stages stalled
    stall = 6'b11_0000;
    flush = 1'b1;
    tick();
    check_entry("flush_hold", 1'b0, 3'b000, 15'd0, 96'd0);
    check_cnt("flush_hold", 3, 5, 3, 5);
    flush = 1'b0;

    // T6 20 more bubbles: 16-bit counter reaches 23, 4-bit saturates at F
    stall = 6'b01_0000;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    check_cnt("saturate", 23, 5, 15, 5);
    check_entry("after_bubbles", 1'b0, 3'b000, 15'd0, 96'd0);

    // Only reset clears the counters
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cnt("reset_again", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish required finish within 100000");
    $fatal(1, "timeout");
  end

endmodule
